// File: rtl/ccd_pixel_packer.sv
// ccd_pixel_packer: packs AD9826 pixel byte pairs into framed line packets for a tx FIFO (optional trailing XOR checksum byte with `PIXEL_CHECKSUM_EN)
module ccd_pixel_packer #(
  parameter int         BUF_AW   = 3,
  parameter logic [7:0] HDR_BYTE = 8'hC0,
  parameter logic [7:0] TRL_BYTE = 8'hC1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ad_data,
  input  logic       ad_msb_valid,
  input  logic       ad_lsb_valid,
  input  logic       frame_start,
  input  logic       line_start,
  input  logic       line_end,
  input  logic       wfull,
  output logic [7:0] wdata,
  output logic       winc,
  output logic       busy,
  output logic       overflow,
  output logic       proto_err
);
  typedef enum logic [3:0] {
    IDLE, HDR, LN_MSB, LN_LSB, PIX_WAIT, PIX_MSB, PIX_LSB, TRL, CNT_MSB, CNT_LSB
`ifdef PIXEL_CHECKSUM_EN
    , CSUM
`endif
  } state_t;
  state_t            r_state, w_next;
  logic [BUF_AW:0]   r_wr, r_rd;
  logic [15:0]       r_mem [2**BUF_AW];
  logic [7:0]        r_hold;
  logic              r_msb_pend, r_end_pend;
  logic [15:0]       r_line, r_cnt;
  logic              r_ovf, r_perr;
  logic [7:0]        w_byte;
  logic              w_emit, w_idle, w_empty, w_full, w_pix, w_pop, w_push, w_drop, w_perr;
  logic [15:0]       w_head;
`ifdef PIXEL_CHECKSUM_EN
  logic [7:0]        r_csum;
`endif
  assign w_idle    = r_state == IDLE;
  assign w_empty   = r_wr == r_rd;
  assign w_full    = r_wr == {~r_rd[BUF_AW], r_rd[BUF_AW-1:0]};
  assign w_head    = r_mem[r_rd[BUF_AW-1:0]];
  assign winc      = w_emit & ~wfull;
  assign wdata     = w_emit ? w_byte : 8'h00;
  assign busy      = ~w_idle;
  assign overflow  = r_ovf;
  assign proto_err = r_perr;
  // A completed byte pair; pushes outside a packet are discarded silently.
  assign w_pix  = ad_lsb_valid & ~ad_msb_valid & r_msb_pend;
  assign w_pop  = winc & (r_state == PIX_LSB);
  // A simultaneous pop frees the slot, so a full buffer still accepts the push.
  assign w_push = w_pix & ~w_idle & (~w_full | w_pop);
  assign w_drop = w_pix & ~w_idle & w_full & ~w_pop;
  assign w_perr = (ad_msb_valid & ad_lsb_valid) | (ad_lsb_valid & ~ad_msb_valid & ~r_msb_pend) |
                  (line_end & w_idle) | ((line_start | frame_start) & ~w_idle);
  // Byte selection and next state; emitting states only advance when the byte is accepted.
  always_comb begin
    w_next = r_state;
    w_byte = 8'h00;
    w_emit = 1'b1;
    case (r_state)
      IDLE:     begin w_emit = 1'b0; w_next = line_start ? HDR : IDLE; end
      HDR:      begin w_byte = HDR_BYTE;     w_next = LN_MSB; end
      LN_MSB:   begin w_byte = r_line[15:8]; w_next = LN_LSB; end
      LN_LSB:   begin w_byte = r_line[7:0];  w_next = PIX_WAIT; end
      PIX_WAIT: begin w_emit = 1'b0; w_next = !w_empty ? PIX_MSB : r_end_pend ? TRL : PIX_WAIT; end
      PIX_MSB:  begin w_byte = w_head[15:8]; w_next = PIX_LSB; end
      PIX_LSB:  begin w_byte = w_head[7:0];  w_next = PIX_WAIT; end
      TRL:      begin w_byte = TRL_BYTE;     w_next = CNT_MSB; end
      CNT_MSB:  begin w_byte = r_cnt[15:8];  w_next = CNT_LSB; end
`ifdef PIXEL_CHECKSUM_EN
      CNT_LSB:  begin w_byte = r_cnt[7:0];   w_next = CSUM; end
      CSUM:     begin w_byte = r_csum;       w_next = IDLE; end
`else
      CNT_LSB:  begin w_byte = r_cnt[7:0];   w_next = IDLE; end
`endif
      default:  begin w_emit = 1'b0; w_next = IDLE; end
    endcase
    if (w_emit & wfull) w_next = r_state;
  end
  // State register.
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  // Pixel storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr[BUF_AW-1:0]] <= {r_hold, ad_data};
  // Capture, buffer pointers, packet counters and sticky flags.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wr       <= '0;
      r_rd       <= '0;
      r_hold     <= '0;
      r_msb_pend <= 1'b0;
      r_end_pend <= 1'b0;
      r_line     <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_perr     <= 1'b0;
    end else begin
      if (ad_msb_valid & ~ad_lsb_valid) begin
        r_hold     <= ad_data;
        r_msb_pend <= 1'b1;
      end else if (ad_lsb_valid & ~ad_msb_valid) r_msb_pend <= 1'b0;
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) begin
        r_rd  <= r_rd + 1'b1;
        r_cnt <= r_cnt + 16'd1;
      end
      if (w_idle & line_start) begin
        r_cnt      <= '0;
        r_end_pend <= 1'b0;
      end else if (~w_idle & line_end) r_end_pend <= 1'b1;
      if (w_idle & frame_start) r_line <= '0;
      else if (winc & (r_state == CNT_LSB)) r_line <= r_line + 16'd1;
      if (w_drop) r_ovf <= 1'b1;
      if (w_perr) r_perr <= 1'b1;
    end
`ifdef PIXEL_CHECKSUM_EN
  // Running XOR of every accepted packet byte, consumed by the checksum byte.
  always_ff @(posedge clk or posedge rst)
    if (rst) r_csum <= '0;
    else if (winc) r_csum <= (r_state == CSUM) ? 8'h00 : r_csum ^ wdata;
`endif
endmodule

// File: tb/tb_ccd_pixel_packer.sv
// tb_ccd_pixel_packer: directed self-checking bench for ccd_pixel_packer
module tb_ccd_pixel_packer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ad_data = '0;
  logic       ad_msb_valid = 1'b0, ad_lsb_valid = 1'b0;
  logic       frame_start = 1'b0, line_start = 1'b0, line_end = 1'b0;
  logic       wfull = 1'b0;
  logic [7:0] wdata;
  logic       winc, busy, overflow, proto_err;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         n_chk = 0, n_fail = 0;
  ccd_pixel_packer dut (
    .clk(clk), .rst(rst), .ad_data(ad_data), .ad_msb_valid(ad_msb_valid),
    .ad_lsb_valid(ad_lsb_valid), .frame_start(frame_start), .line_start(line_start),
    .line_end(line_end), .wfull(wfull), .wdata(wdata), .winc(winc), .busy(busy),
    .overflow(overflow), .proto_err(proto_err)
  );
  always #5 clk = ~clk;
  // Capture every byte the FIFO accepts, sampled mid-cycle.
  always @(negedge clk) if (winc) got_q.push_back(wdata);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    wfull = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    got_q.delete();
  endtask
  task automatic pix(input logic [15:0] w);
    ad_data = w[15:8];
    ad_msb_valid = 1'b1;
    tick();
    ad_msb_valid = 1'b0;
    ad_data = w[7:0];
    ad_lsb_valid = 1'b1;
    tick();
    ad_lsb_valid = 1'b0;
  endtask
  task automatic pulse_ls();
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask
  task automatic pulse_le();
    line_end = 1'b1;
    tick();
    line_end = 1'b0;
  endtask
  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask
  task automatic wait_bytes(input string tag, input int cnt);
    int n = 0;
    while (got_q.size() < cnt && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_reach"}, got_q.size(), cnt);
  endtask
  task automatic check_stream(input string tag);
`ifdef PIXEL_CHECKSUM_EN
    logic [7:0] x = 8'h00;
    foreach (exp_q[i]) x ^= exp_q[i];
    exp_q.push_back(x);
`endif
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    foreach (exp_q[i])
      chk($sformatf("%s_b%0d", tag, i), i < got_q.size() ? {24'd0, got_q[i]} : 32'hDEAD, {24'd0, exp_q[i]});
    got_q.delete();
    exp_q.delete();
  endtask
  task automatic empty_line(input string tag, input logic [15:0] ln);
    pulse_ls();
    pulse_le();
    wait_idle(tag);
    exp_q = '{8'hC0, ln[15:8], ln[7:0], 8'hC1, 8'h00, 8'h00};
    check_stream(tag);
  endtask
  initial begin
    int bad;
    #2;
    chk("rst_out", {wdata, winc, busy, overflow, proto_err}, 32'd0);
    do_reset();
    chk("idle_busy", {31'd0, busy}, 32'd0);
    // Basic three-pixel line.
    pulse_ls();
    pix(16'h1234);
    pix(16'hABCD);
    pix(16'h0001);
    pulse_le();
    wait_idle("basic");
    exp_q = '{8'hC0, 8'h00, 8'h00, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hC1, 8'h00, 8'h03};
    check_stream("basic");
    chk("basic_flags", {30'd0, overflow, proto_err}, 32'd0);
    // Backpressure mid-pixel: hold for 10 cycles, stream unchanged.
    pulse_ls();
    pix(16'h1234);
    wait_bytes("stall", 4);
    wfull = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (winc !== 1'b0 || wdata !== 8'h34) bad++;
      tick();
    end
    chk("stall_hold", bad, 0);
    chk("stall_cnt", got_q.size(), 4);
    wfull = 1'b0;
    pix(16'hABCD);
    pix(16'h0001);
    pulse_le();
    wait_idle("stall");
    exp_q = '{8'hC0, 8'h00, 8'h01, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hC1, 8'h00, 8'h03};
    check_stream("stall");
    // Overflow: nine pixels into an eight-deep buffer while the FIFO is full.
    wfull = 1'b1;
    pulse_ls();
    for (int i = 0; i < 9; i++) pix(16'h0100 + 16'(i));
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    pulse_le();
    wfull = 1'b0;
    wait_idle("ovf");
    exp_q = '{8'hC0, 8'h00, 8'h02};
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'h01);
      exp_q.push_back(8'(i));
    end
    exp_q.push_back(8'hC1);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h08);
    check_stream("ovf");
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    // Illegal strobe sequences push nothing.
    do_reset();
    chk("rst_clear", {30'd0, overflow, proto_err}, 32'd0);
    pulse_ls();
    ad_data = 8'h55;
    ad_msb_valid = 1'b1;
    ad_lsb_valid = 1'b1;
    tick();
    ad_msb_valid = 1'b0;
    ad_lsb_valid = 1'b0;
    chk("perr_both", {31'd0, proto_err}, 32'd1);
    ad_lsb_valid = 1'b1;
    tick();
    ad_lsb_valid = 1'b0;
    pulse_le();
    wait_idle("perr");
    exp_q = '{8'hC0, 8'h00, 8'h00, 8'hC1, 8'h00, 8'h00};
    check_stream("perr");
    // Reset mid-pixel abandons the packet and restarts line numbering.
    pulse_ls();
    pix(16'h1234);
    wait_bytes("arst", 4);
    wfull = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out", {wdata, winc, busy, overflow, proto_err}, 32'd0);
    tick();
    rst = 1'b0;
    wfull = 1'b0;
    repeat (5) tick();
    chk("arst_quiet", got_q.size(), 4);
    got_q.delete();
    empty_line("arst_ln", 16'h0000);
    // Frame start resets the line counter.
    do_reset();
    empty_line("fr0", 16'h0000);
    empty_line("fr1", 16'h0001);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    empty_line("fr2", 16'h0000);
    chk("fr_perr", {31'd0, proto_err}, 32'd0);
    // Line end while idle is a protocol error.
    pulse_le();
    chk("le_idle_perr", {31'd0, proto_err}, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
